// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the data-RAM access controller.
// Holds the access-size codes, port ids, FSM states and the lane-merge function.
package dmem_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_MERGE   = 2'd2
  } state_t;

  // Size code 3 behaves as a word.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SIZE_B:  mis = 1'b0;
      SIZE_H:  mis = addr_lo[0];
      default: mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

  // Replace the addressed byte/half of a RAM word with right-justified store data.
  function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                             input logic [31:0] wdata,
                                             input logic [1:0]  size,
                                             input logic [1:0]  addr_lo);
    logic [31:0] res;
    res = word;
    case (size)
      SIZE_B: begin
        case (addr_lo)
          2'd0:    res[7:0]   = wdata[7:0];
          2'd1:    res[15:8]  = wdata[7:0];
          2'd2:    res[23:16] = wdata[7:0];
          default: res[31:24] = wdata[7:0];
        endcase
      end
      SIZE_H: begin
        if (addr_lo[1]) res[31:16] = wdata[15:0];
        else            res[15:0]  = wdata[15:0];
      end
      default: res = wdata;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dmem_rr_arb.sv
// Two-way CPU/debug arbiter: round-robin on conflict, or fixed debug priority.
// last_grant resets to debug so the CPU wins the first conflict.
module dmem_rr_arb
  import dmem_pkg::*;
#(
  parameter int DBG_PRIO = 0
) (
  input  logic clk,
  input  logic rst_b,
  input  logic en,
  input  logic cpu_req,
  input  logic dbg_req,
  output logic grant_valid,
  output logic grant_port
);

  logic last_grant;

  always_comb begin
    grant_valid = en & (cpu_req | dbg_req);
    grant_port  = PORT_CPU;
    if (cpu_req && dbg_req) begin
      if (DBG_PRIO != 0)                 grant_port = PORT_DBG;
      else if (last_grant == PORT_DBG)   grant_port = PORT_CPU;
      else                               grant_port = PORT_DBG;
    end else if (dbg_req) begin
      grant_port = PORT_DBG;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      last_grant <= PORT_DBG;
    end else if (grant_valid) begin
      last_grant <= grant_port;
    end
  end

endmodule

// File: rtl/dmem_access_ctl.sv
// Sequencer/arbiter for the single-port data RAM shared by the CPU pipeline and debug port.
// Sub-word stores run as read-modify-write; hold_ctl stalls the pipeline until accepted.
//
//   state      | meaning
//   ST_IDLE    | arbitrate, issue word store / read, flag misaligned CPU access
//   ST_RD_WAIT | RAM read data arriving; respond (load) or capture for merge (rmw)
//   ST_MERGE   | write merged word back for a byte/half store
module dmem_access_ctl
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DBG_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              cpu_req_valid,
  input  logic              cpu_req_wen,
  input  logic [1:0]        cpu_req_size,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic [31:0]       cpu_req_wdata,
  output logic              cpu_req_ready,
  output logic              cpu_rsp_valid,
  output logic [31:0]       cpu_rsp_rdata,
  input  logic              dbg_req_valid,
  input  logic              dbg_req_wen,
  input  logic [ADDR_W-1:0] dbg_req_addr,
  input  logic [31:0]       dbg_req_wdata,
  output logic              dbg_req_ready,
  output logic              dbg_rsp_valid,
  output logic [31:0]       dbg_rsp_rdata,
  output logic              mem_cs_en,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              hold_ctl,
  output logic              misalign_err
);

  state_t            state_q, state_d;
  logic              rmw_q, rmw_d;
  logic              mis_rsp_q, mis_rsp_d;
  logic              port_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic [31:0]       wdata_q;
  logic [31:0]       merge_q;

  logic              grant_valid;
  logic              grant_port;
  logic              g_wen;
  logic [1:0]        g_size;
  logic [ADDR_W-1:0] g_addr;
  logic [31:0]       g_wdata;
  logic              g_mis;

  // Arbitration is held off during reset so nothing is issued while rst_b is low.
  dmem_rr_arb #(.DBG_PRIO(DBG_PRIO)) u_arb (
    .clk         (clk),
    .rst_b       (rst_b),
    .en          ((state_q == ST_IDLE) && rst_b),
    .cpu_req     (cpu_req_valid),
    .dbg_req     (dbg_req_valid),
    .grant_valid (grant_valid),
    .grant_port  (grant_port)
  );

  always_comb begin
    if (grant_port == PORT_CPU) begin
      g_wen   = cpu_req_wen;
      g_size  = cpu_req_size;
      g_addr  = cpu_req_addr;
      g_wdata = cpu_req_wdata;
      g_mis   = is_misaligned(cpu_req_size, cpu_req_addr[1:0]);
    end else begin
      g_wen   = dbg_req_wen;
      g_size  = SIZE_W;
      g_addr  = dbg_req_addr;
      g_wdata = dbg_req_wdata;
      g_mis   = 1'b0;
    end
  end

  always_comb begin
    state_d       = state_q;
    rmw_d         = rmw_q;
    mis_rsp_d     = 1'b0;
    cpu_req_ready = 1'b0;
    dbg_req_ready = 1'b0;
    cpu_rsp_valid = mis_rsp_q;
    cpu_rsp_rdata = '0;
    dbg_rsp_valid = 1'b0;
    dbg_rsp_rdata = '0;
    mem_cs_en     = 1'b0;
    mem_wen       = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    misalign_err  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          cpu_req_ready = (grant_port == PORT_CPU);
          dbg_req_ready = (grant_port == PORT_DBG);
          if (g_mis) begin
            misalign_err = 1'b1;
            mis_rsp_d    = ~g_wen;
          end else if (g_wen && g_size[1]) begin
            mem_cs_en = 1'b1;
            mem_wen   = 1'b1;
            mem_addr  = {g_addr[ADDR_W-1:2], 2'b00};
            mem_wdata = g_wdata;
          end else begin
            mem_cs_en = 1'b1;
            mem_addr  = {g_addr[ADDR_W-1:2], 2'b00};
            rmw_d     = g_wen;
            state_d   = ST_RD_WAIT;
          end
        end
      end
      ST_RD_WAIT: begin
        if (rmw_q) begin
          state_d = ST_MERGE;
        end else begin
          if (port_q == PORT_CPU) begin
            cpu_rsp_valid = 1'b1;
            cpu_rsp_rdata = mem_rdata;
          end else begin
            dbg_rsp_valid = 1'b1;
            dbg_rsp_rdata = mem_rdata;
          end
          state_d = ST_IDLE;
        end
      end
      ST_MERGE: begin
        mem_cs_en = 1'b1;
        mem_wen   = 1'b1;
        mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
        mem_wdata = lane_merge(merge_q, wdata_q, size_q, addr_q[1:0]);
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign hold_ctl = cpu_req_valid & ~cpu_req_ready;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= ST_IDLE;
      rmw_q     <= 1'b0;
      mis_rsp_q <= 1'b0;
      port_q    <= PORT_CPU;
      addr_q    <= '0;
      size_q    <= SIZE_W;
      wdata_q   <= '0;
      merge_q   <= '0;
    end else begin
      state_q   <= state_d;
      rmw_q     <= rmw_d;
      mis_rsp_q <= mis_rsp_d;
      if (grant_valid) begin
        port_q  <= grant_port;
        addr_q  <= g_addr;
        size_q  <= g_size;
        wdata_q <= g_wdata;
      end
      if (state_q == ST_RD_WAIT && rmw_q) begin
        merge_q <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_access_ctl.sv
// Self-checking bench for dmem_access_ctl: directed vector table, corner sequences,
// and random CPU traffic against a byte-array memory model.
module tb_dmem_access_ctl;

  logic clk = 1'b0;
  logic rst_b;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // round-robin instance
  logic        c_valid, c_wen, c_ready, c_rsp_valid;
  logic [1:0]  c_size;
  logic [31:0] c_addr, c_wdata, c_rsp_rdata;
  logic        d_valid, d_wen, d_ready, d_rsp_valid;
  logic [31:0] d_addr, d_wdata, d_rsp_rdata;
  logic        m_cs, m_wen, hold, mis;
  logic [31:0] m_addr, m_wdata, m_rdata;

  // debug-priority instance
  logic        pc_valid, pc_wen, pc_ready, pc_rsp_valid;
  logic [1:0]  pc_size;
  logic [31:0] pc_addr, pc_wdata, pc_rsp_rdata;
  logic        pd_valid, pd_wen, pd_ready, pd_rsp_valid;
  logic [31:0] pd_addr, pd_wdata, pd_rsp_rdata;
  logic        pm_cs, pm_wen, p_hold, p_mis;
  logic [31:0] pm_addr, pm_wdata;
  logic [31:0] pm_rdata = 32'h0;

  dmem_access_ctl #(.ADDR_W(32), .DBG_PRIO(0)) dut (
    .clk(clk), .rst_b(rst_b),
    .cpu_req_valid(c_valid), .cpu_req_wen(c_wen), .cpu_req_size(c_size),
    .cpu_req_addr(c_addr), .cpu_req_wdata(c_wdata), .cpu_req_ready(c_ready),
    .cpu_rsp_valid(c_rsp_valid), .cpu_rsp_rdata(c_rsp_rdata),
    .dbg_req_valid(d_valid), .dbg_req_wen(d_wen), .dbg_req_addr(d_addr),
    .dbg_req_wdata(d_wdata), .dbg_req_ready(d_ready),
    .dbg_rsp_valid(d_rsp_valid), .dbg_rsp_rdata(d_rsp_rdata),
    .mem_cs_en(m_cs), .mem_wen(m_wen), .mem_addr(m_addr), .mem_wdata(m_wdata),
    .mem_rdata(m_rdata), .hold_ctl(hold), .misalign_err(mis)
  );

  dmem_access_ctl #(.ADDR_W(32), .DBG_PRIO(1)) dut_prio (
    .clk(clk), .rst_b(rst_b),
    .cpu_req_valid(pc_valid), .cpu_req_wen(pc_wen), .cpu_req_size(pc_size),
    .cpu_req_addr(pc_addr), .cpu_req_wdata(pc_wdata), .cpu_req_ready(pc_ready),
    .cpu_rsp_valid(pc_rsp_valid), .cpu_rsp_rdata(pc_rsp_rdata),
    .dbg_req_valid(pd_valid), .dbg_req_wen(pd_wen), .dbg_req_addr(pd_addr),
    .dbg_req_wdata(pd_wdata), .dbg_req_ready(pd_ready),
    .dbg_rsp_valid(pd_rsp_valid), .dbg_rsp_rdata(pd_rsp_rdata),
    .mem_cs_en(pm_cs), .mem_wen(pm_wen), .mem_addr(pm_addr), .mem_wdata(pm_wdata),
    .mem_rdata(pm_rdata), .hold_ctl(p_hold), .misalign_err(p_mis)
  );

  // Synchronous single-port RAM: read data one cycle after a read.
  logic [31:0] ram [0:63];
  int          wr_count = 0;
  logic [31:0] last_wr  = 32'h0;
  always @(posedge clk) begin
    if (m_cs) begin
      if (m_wen) begin
        ram[m_addr[7:2]] = m_wdata;
        wr_count = wr_count + 1;
        last_wr  = m_wdata;
      end else begin
        m_rdata <= ram[m_addr[7:2]];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  // One CPU access: wait for grant, then watch 4 cycles for a response.
  task automatic cpu_txn(input logic wen, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic got_mis, output logic got_rsp,
                         output logic [31:0] rdata, output int lat);
    int n;
    @(negedge clk);
    c_valid = 1'b1; c_wen = wen; c_size = size; c_addr = addr; c_wdata = wdata;
    #1;
    n = 0;
    while (!c_ready && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    check("cpu_grant", {31'h0, c_ready}, 32'h1);
    got_mis = mis;
    @(posedge clk); #1;
    c_valid = 1'b0;
    got_rsp = 1'b0; rdata = 32'h0; lat = 0;
    for (int k = 1; k <= 4; k++) begin
      if (c_rsp_valid && !got_rsp) begin
        got_rsp = 1'b1; rdata = c_rsp_rdata; lat = k;
      end
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    logic        wen;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] init;
    logic [31:0] exp_word;
    logic        exp_mis;
    logic        exp_rsp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [10];

  logic [7:0] ref_b [0:63];
  byte        g0 [8];
  byte        g1 [8];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        tm, tr;
    logic [31:0] td;
    int          tl, wc0, hc, n0, n1, ci0, di0, ci1, di1;

    vecs[0] = '{1'b0, 2'd2, 32'h10, 32'h0,        32'hA5A5_1234, 32'hA5A5_1234, 1'b0, 1'b1, 32'hA5A5_1234};
    vecs[1] = '{1'b1, 2'd0, 32'h13, 32'hEE,       32'h1122_3344, 32'hEE22_3344, 1'b0, 1'b0, 32'h0};
    vecs[2] = '{1'b1, 2'd1, 32'h22, 32'hBEEF,     32'h0000_0000, 32'hBEEF_0000, 1'b0, 1'b0, 32'h0};
    vecs[3] = '{1'b1, 2'd1, 32'h21, 32'hBEEF,     32'h0102_0304, 32'h0102_0304, 1'b1, 1'b0, 32'h0};
    vecs[4] = '{1'b0, 2'd2, 32'h32, 32'h0,        32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h0};
    vecs[5] = '{1'b1, 2'd0, 32'h24, 32'h5A,       32'hFFFF_FFFF, 32'hFFFF_FF5A, 1'b0, 1'b0, 32'h0};
    vecs[6] = '{1'b1, 2'd1, 32'h28, 32'h1234_CAFE,32'hAAAA_AAAA, 32'hAAAA_CAFE, 1'b0, 1'b0, 32'h0};
    vecs[7] = '{1'b1, 2'd3, 32'h2C, 32'h0123_4567,32'h0000_0000, 32'h0123_4567, 1'b0, 1'b0, 32'h0};
    vecs[8] = '{1'b1, 2'd2, 32'h31, 32'h5555_5555,32'h0000_0077, 32'h0000_0077, 1'b1, 1'b0, 32'h0};
    vecs[9] = '{1'b1, 2'd0, 32'h35, 32'hFF00,     32'hFFFF_FFFF, 32'hFFFF_00FF, 1'b0, 1'b0, 32'h0};

    c_valid = 0; c_wen = 0; c_size = 0; c_addr = 0; c_wdata = 0;
    d_valid = 0; d_wen = 0; d_addr = 0; d_wdata = 0;
    pc_valid = 0; pc_wen = 0; pc_size = 0; pc_addr = 0; pc_wdata = 0;
    pd_valid = 0; pd_wen = 0; pd_addr = 0; pd_wdata = 0;
    for (int i = 0; i < 64; i++) ram[i] = 32'h0;
    rst_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cs",    {31'h0, m_cs},        32'h0);
    check("rst_wen",   {31'h0, m_wen},       32'h0);
    check("rst_rsp",   {31'h0, c_rsp_valid}, 32'h0);
    check("rst_ready", {31'h0, c_ready},     32'h0);
    check("rst_mis",   {31'h0, mis},         32'h0);
    check("rst_hold",  {31'h0, hold},        32'h0);
    @(negedge clk);
    rst_b = 1'b1;

    // random CPU traffic vs byte-array model, words 0..15
    for (int i = 0; i < 16; i++) begin
      ram[i] = $urandom;
      for (int j = 0; j < 4; j++) ref_b[i*4+j] = 8'(ram[i] >> (8*j));
    end
    for (int it = 0; it < 60; it++) begin
      logic        wen, emis;
      logic [1:0]  sz;
      logic [31:0] a, wd, erd;
      int          base, nb;
      wen  = 1'($urandom_range(0, 1));
      sz   = 2'($urandom_range(0, 3));
      a    = 32'($urandom_range(0, 63));
      wd   = $urandom;
      emis = (sz == 2'd1 && a[0]) || (sz >= 2'd2 && a[1:0] != 2'b00);
      base = int'(a) & ~3;
      erd  = emis ? 32'h0 : {ref_b[base+3], ref_b[base+2], ref_b[base+1], ref_b[base]};
      if (wen && !emis) begin
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        for (int j = 0; j < nb; j++) ref_b[int'(a)+j] = 8'(wd >> (8*j));
      end
      cpu_txn(wen, sz, a, wd, tm, tr, td, tl);
      check("rnd_mis", {31'h0, tm}, {31'h0, emis});
      check("rnd_rsp", {31'h0, tr}, {31'h0, ~wen});
      if (!wen) check("rnd_rdata", td, erd);
    end
    for (int i = 0; i < 16; i++)
      check("rnd_mem", ram[i], {ref_b[i*4+3], ref_b[i*4+2], ref_b[i*4+1], ref_b[i*4]});

    // directed vector table
    for (int v = 0; v < 10; v++) begin
      ram[vecs[v].addr[7:2]] = vecs[v].init;
      cpu_txn(vecs[v].wen, vecs[v].size, vecs[v].addr, vecs[v].wdata, tm, tr, td, tl);
      check("vec_mis", {31'h0, tm}, {31'h0, vecs[v].exp_mis});
      check("vec_rsp", {31'h0, tr}, {31'h0, vecs[v].exp_rsp});
      if (vecs[v].exp_rsp) begin
        check("vec_rdata", td, vecs[v].exp_rdata);
        check("vec_latency", 32'(tl), 32'd1);
      end
      check("vec_mem", ram[vecs[v].addr[7:2]], vecs[v].exp_word);
    end

    // sb followed by a held load: 2 hold cycles, then load sees merged word
    ram[4] = 32'h1122_3344;
    @(negedge clk);
    c_valid = 1; c_wen = 1; c_size = 2'd0; c_addr = 32'h13; c_wdata = 32'hEE;
    #1;
    check("sb_ready", {31'h0, c_ready}, 32'h1);
    check("sb_hold0", {31'h0, hold},    32'h0);
    check("sb_rd_issue", {30'h0, m_cs, m_wen}, 32'h2);
    @(posedge clk); #1;
    c_wen = 0; c_size = 2'd2; c_addr = 32'h10; c_wdata = 0;
    hc = 0;
    while (hold && hc < 10) begin
      hc++;
      @(posedge clk); #1;
    end
    check("sb_hold_cycles", 32'(hc), 32'd2);
    check("sb_merge_write", last_wr, 32'hEE22_3344);
    check("lw_ready", {31'h0, c_ready}, 32'h1);
    @(posedge clk); #1;
    c_valid = 0;
    check("lw_rsp", {31'h0, c_rsp_valid}, 32'h1);
    check("lw_rdata", c_rsp_rdata, 32'hEE22_3344);
    repeat (2) @(posedge clk);

    // back-to-back word stores
    wc0 = wr_count;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      c_valid = 1; c_wen = 1; c_size = 2'd2; c_addr = 32'(i*4); c_wdata = 32'h1000 + 32'(i);
      #1;
      check("b2b_ready", {31'h0, c_ready}, 32'h1);
      check("b2b_hold",  {31'h0, hold},    32'h0);
      check("b2b_write", {30'h0, m_cs, m_wen}, 32'h3);
      check("b2b_addr",  m_addr, 32'(i*4));
      @(posedge clk); #1;
    end
    c_valid = 0;
    check("b2b_count", 32'(wr_count - wc0), 32'd4);
    for (int i = 0; i < 4; i++) check("b2b_mem", ram[i], 32'h1000 + 32'(i));

    // debug port write then read
    @(negedge clk);
    d_valid = 1; d_wen = 1; d_addr = 32'h80; d_wdata = 32'hCAFE_F00D;
    #1;
    check("dbg_wr_ready", {31'h0, d_ready}, 32'h1);
    @(posedge clk); #1;
    d_valid = 0;
    check("dbg_wr_mem", ram[32], 32'hCAFE_F00D);
    @(negedge clk);
    d_valid = 1; d_wen = 0;
    #1;
    check("dbg_rd_ready", {31'h0, d_ready}, 32'h1);
    @(posedge clk); #1;
    d_valid = 0;
    check("dbg_rsp", {30'h0, d_rsp_valid, c_rsp_valid}, 32'h2);
    check("dbg_rdata", d_rsp_rdata, 32'hCAFE_F00D);
    repeat (2) @(posedge clk);

    // simultaneous CPU/debug streams, both arbitration modes, fresh from reset
    @(negedge clk); rst_b = 0;
    @(negedge clk); rst_b = 1;
    for (int i = 0; i < 8; i++) begin g0[i] = "-"; g1[i] = "-"; end
    n0 = 0; n1 = 0; ci0 = 0; di0 = 0; ci1 = 0; di1 = 0;
    for (int cyc = 0; cyc < 20 && (n0 < 8 || n1 < 8); cyc++) begin
      @(posedge clk); #1;
      c_valid  = (ci0 < 4); c_wen  = 1; c_size  = 2'd2; c_addr  = 32'h40 + 32'(ci0*4); c_wdata  = 32'(ci0);
      d_valid  = (di0 < 4); d_wen  = 1; d_addr  = 32'h60 + 32'(di0*4); d_wdata  = 32'(di0);
      pc_valid = (ci1 < 4); pc_wen = 1; pc_size = 2'd2; pc_addr = 32'h40 + 32'(ci1*4); pc_wdata = 32'(ci1);
      pd_valid = (di1 < 4); pd_wen = 1; pd_addr = 32'h60 + 32'(di1*4); pd_wdata = 32'(di1);
      @(negedge clk);
      if (n0 < 8) begin
        if (c_ready)      begin g0[n0] = "C"; n0++; ci0++; end
        else if (d_ready) begin g0[n0] = "D"; n0++; di0++; end
      end
      if (n1 < 8) begin
        if (pc_ready)      begin g1[n1] = "C"; n1++; ci1++; end
        else if (pd_ready) begin g1[n1] = "D"; n1++; di1++; end
      end
    end
    @(posedge clk); #1;
    c_valid = 0; d_valid = 0; pc_valid = 0; pd_valid = 0;
    for (int i = 0; i < 8; i++) begin
      check("rr_grant",   32'(g0[i]), (i % 2 == 0) ? 32'("C") : 32'("D"));
      check("prio_grant", 32'(g1[i]), (i < 4) ? 32'("D") : 32'("C"));
    end

    // reset during MERGE of sb 0x40
    ram[16] = 32'h1111_1111;
    @(negedge clk);
    c_valid = 1; c_wen = 1; c_size = 2'd0; c_addr = 32'h40; c_wdata = 32'h22;
    #1;
    check("rst_sb_ready", {31'h0, c_ready}, 32'h1);
    @(posedge clk); #1;
    c_valid = 0;
    @(posedge clk); #1;
    check("rst_in_merge", {30'h0, m_cs, m_wen}, 32'h3);
    wc0 = wr_count;
    rst_b = 0;
    #1;
    check("rst_mid_outs", {28'h0, m_cs, m_wen, c_rsp_valid, mis}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_mid_nowrite", 32'(wr_count - wc0), 32'd0);
    check("rst_mid_mem", ram[16], 32'h1111_1111);
    check("rst_mid_rsp", {31'h0, c_rsp_valid}, 32'h0);
    @(negedge clk);
    rst_b = 1;
    @(negedge clk);
    c_valid = 1; c_wen = 1; c_size = 2'd2; c_addr = 32'h44; c_wdata = 32'h5;
    d_valid = 1; d_wen = 1; d_addr = 32'h48; d_wdata = 32'h6;
    #1;
    check("post_rst_conflict", {30'h0, c_ready, d_ready}, 32'h2);
    @(posedge clk); #1;
    c_valid = 0; d_valid = 0;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
